wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the five-stage RV32I pipeline: consumes the MEM/WB pipeline register outputs, selects the writeback value, and commits it to the 32×32 integer register file. It also serves the two decode-stage read ports with same-cycle write bypass, and holds the free-running cycle and retired-instruction counters. It sits between the MEM/WB register and the ID stage's operand read.

## Interface
- No parameters. XLEN fixed at 32. Register count fixed at 32.
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- WB_rf_we  in  1  writeback enable from MEM/WB.
- WB_wd_sel  in  2  writeback source select; encoding in the shared package.
- WB_ALUC  in  32  ALU result.
- WB_DRAMrd  in  32  load data, already extended.
- WB_pc4  in  32  PC+4, used for jal/jalr.
- WB_ext  in  32  immediate, used for lui.
- WB_wR  in  5  destination register index.
- WB_PC  in  32  PC of the instruction in WB.
- wb_have_inst  in  1  a valid instruction occupies WB; 0 marks a bubble.
- ID_rR1, ID_rR2  in  5  decode read indices.
- ID_rD1, ID_rD2  out  32  read data, combinational.
- WB_wD  out  32  selected writeback value, combinational; also feeds forwarding.
- debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg, debug_wb_value  out  1/32/1/5/32  commit trace, registered.
- cycle_cnt  out  64  cycles since reset release.
- instret_cnt  out  64  retired instructions.

## Operation
- WB_wD mux:
  - WD_ALU = 0 selects WB_ALUC.
  - WD_DRAM = 1 selects WB_DRAMrd.
  - WD_PC4 = 2 selects WB_pc4.
  - WD_EXT = 3 selects WB_ext.
- Commit condition: `we_eff = WB_rf_we & wb_have_inst & (WB_wR != 0)`. When true, rf[WB_wR] <= WB_wD at the posedge.
- x0:
  - Reads as 0 always.
  - Never written.
  - Never bypassed.
- Read ports:
  - ID_rDn = 0 if ID_rRn == 0.
  - Else, if we_eff and WB_wR == ID_rRn, ID_rDn = WB_wD (write-through bypass).
  - Else ID_rDn = rf[ID_rRn].
  - The two ports are independent. Both may hit the bypass in the same cycle.
- Trace registers update every posedge:
  - debug_wb_have_inst <= wb_have_inst
  - debug_wb_pc <= WB_PC
  - debug_wb_ena <= we_eff
  - debug_wb_reg <= WB_wR
  - debug_wb_value <= WB_wD
- cycle_cnt increments by 1 every posedge while rst_n is high.
- instret_cnt increments by 1 on every posedge where wb_have_inst = 1, regardless of WB_rf_we, so stores and branches count.
- Both counters wrap from 2^64−1 to 0 with no flag.

## Timing
- Reset (asynchronous assert, synchronous-to-clk release):
  - All 31 architectural registers clear to 0.
  - All debug outputs clear to 0.
  - cycle_cnt and instret_cnt clear to 0.
  - Combinational outputs follow from the cleared state.
- Reset mid-operation: any in-flight commit is discarded. Registers read 0 immediately, not at the next edge.
- Write latency: a value committed at edge N is readable from the array from edge N onward. In the cycle before edge N it is supplied by the bypass, so decode never needs a stall for a WB→ID hazard.
- Trace latency: one cycle after the commit edge.
- Counter visibility: counter outputs reflect increments one cycle after the qualifying cycle.
- Bubble (wb_have_inst = 0) with WB_rf_we = 1: no write, no bypass, instret unchanged.

## Structure
- Shared package pipeline_pkg holds the WD_ALU/WD_DRAM/WD_PC4/WD_EXT localparams and the XLEN = 32 constant. The WB_wd_sel encoder in decode uses the same constants.
- One sub-module, regfile_32x32:
  - Async-reset array, 1 write port, 2 read ports, x0 handling, bypass.
- wb_stage contains:
  - the mux
  - we_eff
  - the trace registers
  - the counters

## Test plan
- Reset: hold rst_n low, then read all 32 indices. Expect every ID_rD = 0, and cycle_cnt = instret_cnt = 0 after release.
- Mux: WB_ALUC = 0x11, WB_DRAMrd = 0x22, WB_pc4 = 0x33, WB_ext = 0x44. Sweep WB_wd_sel 0..3 and expect WB_wD = 0x11, 0x22, 0x33, 0x44.
- Bypass: commit x5 = 0xDEADBEEF with ID_rR1 = ID_rR2 = 5 in the same cycle. Expect both ID_rD = 0xDEADBEEF before the edge and from the array after it.
- x0 and bubble cases:
  - Write x0 = 0xFFFFFFFF with we = 1: x0 reads 0 and debug_wb_ena = 0.
  - Write x7 with wb_have_inst = 0: x7 is unchanged and instret is unchanged.
- Counters: 10 cycles with wb_have_inst pattern 1,0,1,1,0,0,1,1,1,0, including a store with WB_rf_we = 0. Expect cycle_cnt = 10 and instret_cnt = 6.
- Reset mid-stream: assert rst_n low between edges while x9 holds 0x1234. Expect x9 = 0 and counters = 0 immediately, and no commit at the following edge.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: datapath width, register count and the
// writeback-source encoding used by both decode and writeback.
package pipeline_pkg;

  localparam int XLEN = 32;
  localparam int NREG = 32;

  // Writeback source select encoding (WB_wd_sel)
  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_DRAM = 2'd1;
  localparam logic [1:0] WD_PC4  = 2'd2;
  localparam logic [1:0] WD_EXT  = 2'd3;

  // Pick the writeback value for a given source select.
  function automatic logic [XLEN-1:0] wd_select(
    input logic [1:0]      sel,
    input logic [XLEN-1:0] alu,
    input logic [XLEN-1:0] dram,
    input logic [XLEN-1:0] pc4,
    input logic [XLEN-1:0] ext
  );
    logic [XLEN-1:0] res;
    case (sel)
      WD_ALU:  res = alu;
      WD_DRAM: res = dram;
      WD_PC4:  res = pc4;
      WD_EXT:  res = ext;
      default: res = alu;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/regfile_32x32.sv
// 32x32 integer register file: one write port, two combinational read
// ports with write-through bypass. x0 is hardwired to zero.
module regfile_32x32
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we_i,    // already qualified: valid inst, enabled, rd != 0
  input  logic [4:0]      wr_i,
  input  logic [XLEN-1:0] wd_i,
  input  logic [4:0]      rr1_i,
  input  logic [4:0]      rr2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o
);

  logic [XLEN-1:0] rf_q [NREG];
  logic            byp_en_s;

  // A commit being discarded by reset must not be forwarded either, so
  // reads show the cleared array while rst_n is low.
  assign byp_en_s = we_i & rst_n;

  // Register array: async clear, single write port, x0 never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        rf_q[i] <= {XLEN{1'b0}};
      end
    end else begin
      if (we_i && (wr_i != 5'd0)) begin
        rf_q[wr_i] <= wd_i;
      end
    end
  end

  // Read port 1: x0 reads zero, then bypass, then array.
  always_comb begin
    rd1_o = {XLEN{1'b0}};
    if (rr1_i == 5'd0) begin
      rd1_o = {XLEN{1'b0}};
    end else if (byp_en_s && (wr_i == rr1_i)) begin
      rd1_o = wd_i;
    end else begin
      rd1_o = rf_q[rr1_i];
    end
  end

  // Read port 2: same priority as port 1, fully independent.
  always_comb begin
    rd2_o = {XLEN{1'b0}};
    if (rr2_i == 5'd0) begin
      rd2_o = {XLEN{1'b0}};
    end else if (byp_en_s && (wr_i == rr2_i)) begin
      rd2_o = wd_i;
    end else begin
      rd2_o = rf_q[rr2_i];
    end
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: selects the writeback value, commits it to the
// register file, serves decode reads, records a commit trace and keeps
// the cycle / retired-instruction counters.
module wb_stage
  import pipeline_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            WB_rf_we,
  input  logic [1:0]      WB_wd_sel,
  input  logic [31:0]     WB_ALUC,
  input  logic [31:0]     WB_DRAMrd,
  input  logic [31:0]     WB_pc4,
  input  logic [31:0]     WB_ext,
  input  logic [4:0]      WB_wR,
  input  logic [31:0]     WB_PC,
  input  logic            wb_have_inst,
  input  logic [4:0]      ID_rR1,
  input  logic [4:0]      ID_rR2,
  output logic [31:0]     ID_rD1,
  output logic [31:0]     ID_rD2,
  output logic [31:0]     WB_wD,
  output logic            debug_wb_have_inst,
  output logic [31:0]     debug_wb_pc,
  output logic            debug_wb_ena,
  output logic [4:0]      debug_wb_reg,
  output logic [31:0]     debug_wb_value,
  output logic [63:0]     cycle_cnt,
  output logic [63:0]     instret_cnt
);

  logic        we_eff_s;

  logic        trc_have_q, trc_have_d;
  logic [31:0] trc_pc_q,   trc_pc_d;
  logic        trc_ena_q,  trc_ena_d;
  logic [4:0]  trc_reg_q,  trc_reg_d;
  logic [31:0] trc_val_q,  trc_val_d;
  logic [63:0] cycle_q,    cycle_d;
  logic [63:0] instret_q,  instret_d;

  // Writeback value mux; also feeds the forwarding network.
  always_comb begin
    WB_wD = wd_select(WB_wd_sel, WB_ALUC, WB_DRAMrd, WB_pc4, WB_ext);
  end

  // Bubbles and x0 destinations never commit.
  assign we_eff_s = WB_rf_we & wb_have_inst & (WB_wR != 5'd0);

  regfile_32x32 u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we_i  (we_eff_s),
    .wr_i  (WB_wR),
    .wd_i  (WB_wD),
    .rr1_i (ID_rR1),
    .rr2_i (ID_rR2),
    .rd1_o (ID_rD1),
    .rd2_o (ID_rD2)
  );

  // Next-state for trace and counters; counters wrap silently.
  always_comb begin
    trc_have_d = wb_have_inst;
    trc_pc_d   = WB_PC;
    trc_ena_d  = we_eff_s;
    trc_reg_d  = WB_wR;
    trc_val_d  = WB_wD;
    cycle_d    = cycle_q + 64'd1;
    if (wb_have_inst) begin
      instret_d = instret_q + 64'd1;
    end else begin
      instret_d = instret_q;
    end
  end

  // Trace and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trc_have_q <= 1'b0;
      trc_pc_q   <= 32'd0;
      trc_ena_q  <= 1'b0;
      trc_reg_q  <= 5'd0;
      trc_val_q  <= 32'd0;
      cycle_q    <= 64'd0;
      instret_q  <= 64'd0;
    end else begin
      trc_have_q <= trc_have_d;
      trc_pc_q   <= trc_pc_d;
      trc_ena_q  <= trc_ena_d;
      trc_reg_q  <= trc_reg_d;
      trc_val_q  <= trc_val_d;
      cycle_q    <= cycle_d;
      instret_q  <= instret_d;
    end
  end

  assign debug_wb_have_inst = trc_have_q;
  assign debug_wb_pc        = trc_pc_q;
  assign debug_wb_ena       = trc_ena_q;
  assign debug_wb_reg       = trc_reg_q;
  assign debug_wb_value     = trc_val_q;
  assign cycle_cnt          = cycle_q;
  assign instret_cnt        = instret_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed cases plus randomized traffic
// against an architectural register-file model; commit trace checked by a
// queue-based monitor.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        WB_rf_we;
  logic [1:0]  WB_wd_sel;
  logic [31:0] WB_ALUC, WB_DRAMrd, WB_pc4, WB_ext, WB_PC;
  logic [4:0]  WB_wR;
  logic        wb_have_inst;
  logic [4:0]  ID_rR1, ID_rR2;
  logic [31:0] ID_rD1, ID_rD2, WB_wD;
  logic        debug_wb_have_inst, debug_wb_ena;
  logic [31:0] debug_wb_pc, debug_wb_value;
  logic [4:0]  debug_wb_reg;
  logic [63:0] cycle_cnt, instret_cnt;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n), .WB_rf_we(WB_rf_we), .WB_wd_sel(WB_wd_sel),
    .WB_ALUC(WB_ALUC), .WB_DRAMrd(WB_DRAMrd), .WB_pc4(WB_pc4), .WB_ext(WB_ext),
    .WB_wR(WB_wR), .WB_PC(WB_PC), .wb_have_inst(wb_have_inst),
    .ID_rR1(ID_rR1), .ID_rR2(ID_rR2), .ID_rD1(ID_rD1), .ID_rD2(ID_rD2),
    .WB_wD(WB_wD), .debug_wb_have_inst(debug_wb_have_inst),
    .debug_wb_pc(debug_wb_pc), .debug_wb_ena(debug_wb_ena),
    .debug_wb_reg(debug_wb_reg), .debug_wb_value(debug_wb_value),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        have;
    logic [31:0] pc;
    logic        ena;
    logic [4:0]  rg;
    logic [31:0] val;
  } trace_t;

  trace_t      exp_q [$];
  logic [31:0] m_rf [32];
  logic [63:0] m_cyc, m_ret;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: after every edge out of reset, the trace must match the
  // oldest outstanding commit record.
  initial begin
    trace_t e;
    forever begin
      @(posedge clk);
      #2;
      if (rst_n === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("trace_have",  {63'd0, debug_wb_have_inst}, {63'd0, e.have});
        chk("trace_pc",    {32'd0, debug_wb_pc},        {32'd0, e.pc});
        chk("trace_ena",   {63'd0, debug_wb_ena},       {63'd0, e.ena});
        chk("trace_reg",   {59'd0, debug_wb_reg},       {59'd0, e.rg});
        chk("trace_value", {32'd0, debug_wb_value},     {32'd0, e.val});
      end
    end
  end

  // One pipeline cycle: drive, check combinational outputs against the
  // model, queue the expected trace, then advance the model at the edge.
  task automatic step(input logic have, input logic we, input logic [1:0] sel,
                      input logic [4:0] wr, input logic [31:0] alu,
                      input logic [31:0] dram, input logic [31:0] pc4,
                      input logic [31:0] ext, input logic [31:0] pc,
                      input logic [4:0] r1, input logic [4:0] r2);
    logic [31:0] src [4];
    logic [31:0] ew, e1, e2;
    logic        eff;
    trace_t      t;
    @(negedge clk);
    wb_have_inst = have; WB_rf_we = we; WB_wd_sel = sel; WB_wR = wr;
    WB_ALUC = alu; WB_DRAMrd = dram; WB_pc4 = pc4; WB_ext = ext; WB_PC = pc;
    ID_rR1 = r1; ID_rR2 = r2;
    #1;
    src[0] = alu; src[1] = dram; src[2] = pc4; src[3] = ext;
    ew  = src[sel];
    eff = have && we && (wr != 5'd0);
    e1  = (r1 == 5'd0) ? 32'd0 : ((eff && wr == r1) ? ew : m_rf[r1]);
    e2  = (r2 == 5'd0) ? 32'd0 : ((eff && wr == r2) ? ew : m_rf[r2]);
    chk("wb_wd",   {32'd0, WB_wD},  {32'd0, ew});
    chk("id_rd1",  {32'd0, ID_rD1}, {32'd0, e1});
    chk("id_rd2",  {32'd0, ID_rD2}, {32'd0, e2});
    chk("cycle",   cycle_cnt,   m_cyc);
    chk("instret", instret_cnt, m_ret);
    t.have = have; t.pc = pc; t.ena = eff; t.rg = wr; t.val = ew;
    exp_q.push_back(t);
    @(posedge clk);
    if (eff) m_rf[wr] = ew;
    m_cyc = m_cyc + 64'd1;
    if (have) m_ret = m_ret + 64'd1;
  endtask

  // Assert reset between edges with a live commit on the inputs; check
  // everything reads cleared immediately, then release after an edge.
  task automatic apply_reset();
    @(negedge clk);
    wb_have_inst = 1'b1; WB_rf_we = 1'b1; WB_wd_sel = 2'd0; WB_wR = 5'd9;
    WB_ALUC = 32'h0000_5555; WB_DRAMrd = 32'd0; WB_pc4 = 32'd0; WB_ext = 32'd0;
    WB_PC = 32'h0000_0100;
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_cyc = 64'd0;
    m_ret = 64'd0;
    #1;
    for (int i = 0; i < 32; i++) begin
      ID_rR1 = i[4:0];
      ID_rR2 = 5'd31 - i[4:0];
      #1;
      chk("rst_rd1", {32'd0, ID_rD1}, 64'd0);
      chk("rst_rd2", {32'd0, ID_rD2}, 64'd0);
    end
    chk("rst_cycle",   cycle_cnt,   64'd0);
    chk("rst_instret", instret_cnt, 64'd0);
    chk("rst_dbg_have", {63'd0, debug_wb_have_inst}, 64'd0);
    chk("rst_dbg_ena",  {63'd0, debug_wb_ena},       64'd0);
    chk("rst_dbg_pc",   {32'd0, debug_wb_pc},        64'd0);
    chk("rst_dbg_reg",  {59'd0, debug_wb_reg},       64'd0);
    chk("rst_dbg_val",  {32'd0, debug_wb_value},     64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [0:9] pat;
    logic [4:0] wr, r1, r2;
    rst_n = 1'b0;
    WB_rf_we = 1'b0; WB_wd_sel = 2'd0; WB_wR = 5'd0; wb_have_inst = 1'b0;
    WB_ALUC = 32'd0; WB_DRAMrd = 32'd0; WB_pc4 = 32'd0; WB_ext = 32'd0; WB_PC = 32'd0;
    ID_rR1 = 5'd0; ID_rR2 = 5'd0;
    apply_reset();

    // Mux sweep on a bubble so nothing commits.
    for (int s = 0; s < 4; s++)
      step(1'b0, 1'b1, s[1:0], 5'd3, 32'h11, 32'h22, 32'h33, 32'h44,
           32'h1000, 5'd3, 5'd3);

    // Bypass on both ports, then the same value from the array.
    step(1'b1, 1'b1, 2'd0, 5'd5, 32'hDEADBEEF, 32'd0, 32'd0, 32'd0, 32'h1004, 5'd5, 5'd5);
    step(1'b1, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h1008, 5'd5, 5'd5);

    // x0 write attempt.
    step(1'b1, 1'b1, 2'd3, 5'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'h100C, 5'd0, 5'd0);
    step(1'b1, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h1010, 5'd0, 5'd0);

    // Bubble with write enable must neither commit nor bypass.
    step(1'b1, 1'b1, 2'd0, 5'd7, 32'h77, 32'd0, 32'd0, 32'd0, 32'h1014, 5'd0, 5'd0);
    step(1'b0, 1'b1, 2'd0, 5'd7, 32'hBAD, 32'd0, 32'd0, 32'd0, 32'h1018, 5'd7, 5'd7);
    step(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h101C, 5'd7, 5'd7);
    chk("x7_kept", {32'd0, ID_rD1}, 64'h77);

    // Counter pattern from a fresh reset; third slot is a store.
    apply_reset();
    pat = 10'b1011001110;
    for (int k = 0; k < 10; k++)
      step(pat[k], (k == 2) ? 1'b0 : 1'b1, 2'd0, k[4:0] + 5'd1, 32'h100 + k,
           32'd0, 32'd0, 32'd0, 32'h2000 + 4 * k, 5'd1, 5'd2);
    #2;
    chk("cnt_cycle10",  cycle_cnt,   64'd10);
    chk("cnt_instret6", instret_cnt, 64'd6);

    // Randomized traffic with small register indices to force hazards.
    for (int n = 0; n < 400; n++) begin
      wr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      r1 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 7));
      r2 = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom);
      step(($urandom_range(0, 3) != 0), 1'($urandom), 2'($urandom), wr,
           $urandom, $urandom, $urandom, $urandom, $urandom, r1, r2);
    end

    // Reset mid-stream while x9 holds a value.
    step(1'b1, 1'b1, 2'd0, 5'd9, 32'h1234, 32'd0, 32'd0, 32'd0, 32'h3000, 5'd9, 5'd0);
    step(1'b1, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h3004, 5'd9, 5'd9);
    apply_reset();
    step(1'b1, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h3008, 5'd9, 5'd9);
    step(1'b0, 1'b0, 2'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h300C, 5'd9, 5'd9);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
